// File: rtl/sync_circular_fifo.sv
// Parametrised single-clock circular FIFO with occupancy count and almost-full/empty thresholds.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_circular_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow,
`endif
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_empty;
  logic                  r_almost_full;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Acceptance uses the registered flags; flags are then derived from the next count.
  always_comb begin
    w_wr_acc  = write_en && !r_full;
    w_rd_acc  = read_en && !r_empty;
    w_cnt_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_data_out     <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_count        <= w_cnt_nxt;
      r_empty        <= (w_cnt_nxt == '0);
      r_full         <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_almost_empty <= (w_cnt_nxt <= CNT_W'(AE_LEVEL));
      r_almost_full  <= (w_cnt_nxt >= CNT_W'(AF_LEVEL));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the same cycle beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (read_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign data_out     = r_data_out;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;

endmodule

// File: doc/sync_circular_fifo.md
Name: sync_circular_fifo

Overview:
Parametrised single-clock circular FIFO. Generalises the team's 4-bit x 8 linear FIFO to arbitrary width and power-of-two depth, with pointer wrap-around, an occupancy count, almost-full/almost-empty thresholds and simultaneous read/write in one cycle. Used as the standard elastic buffer between same-clock producer and consumer blocks.

Parameters:
DATA_WIDTH, 8, bits per entry (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
write_en  input  1  write request
data_in  input  DATA_WIDTH  write data, sampled when a write is accepted
read_en  input  1  read request
data_out  output  DATA_WIDTH  registered read data
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH

Behaviour:
- Reset: asynchronous on rst rising, held while rst=1. Write pointer=0, read pointer=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0). Memory contents not reset; must not be read before being written.
- Accept rules, evaluated on flag values at the clock edge: write accepted = write_en && !full. Read accepted = read_en && !empty. Rejected requests have no effect on any state.
- Write: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Read: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1. data_out is valid the cycle after the accepting edge and holds until the next accepted read.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 by natural overflow; no reset-to-zero on wrap.
- count: +1 write only, -1 read only, unchanged when both or neither accepted. Never exceeds DEPTH, never below 0.
- All flags are registered and derived from the next count value, so they are correct in the cycle after the edge that changes count. No combinational path from inputs to outputs.
- Simultaneous read+write when full: read accepted, write rejected (full at edge); count becomes DEPTH-1. When empty: write accepted, read rejected; count becomes 1. No write-to-read bypass: data written at edge N is readable at edge N+1 at the earliest.
- Simultaneous read+write, 0<count<DEPTH: both accepted, count and flags unchanged, data ordering preserved.
- Reset mid-operation: all content discarded immediately; first post-reset write lands at address 0.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
Defined: adds ports overflow (output 1), underflow (output 1), err_clr (input 1). overflow set on any edge with write_en && full; underflow set on any edge with read_en && empty. Both sticky until err_clr=1 at an edge or rst. Set wins over err_clr in the same cycle. Reset value 0.
Not defined: ports and logic absent; rejected requests are silently dropped.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) -> immediately empty=1, full=0, count=0, data_out=0, almost_empty=1, almost_full=0.
- Fill/drain, defaults: write 0x00..0x0F over 16 cycles -> full=1, count=16, almost_full from count=12; read 16 -> data_out 0x00..0x0F in order, each one cycle after its read, empty=1 at end.
- Wrap-around: write 10, read 10, write 16 values 0xA0..0xAF, read 16 -> identical order, pointers crossed address 15->0, no corruption.
- Simultaneous R/W: at count=5 assert both for 20 cycles -> count stays 5, output stream equals input stream delayed by 5 entries; at full both asserted -> count 16->15, written value dropped.
- Boundary rejects: write_en on full, read_en on empty -> count, data_out, pointers unchanged; with FIFO_ERR_FLAGS_EN overflow/underflow =1 and held until err_clr pulse, then 0.
- Reset mid-operation: count=7, assert rst -> count=0, empty=1; write 0x55 then read -> data_out=0x55 (not stale data).
